// File: rtl/exec_datapath_core.sv
// ---------------------------------------------------------------------------
// exec_datapath_core
//
// Execute-stage core of a single-cycle RV64I processor. It holds the 32x64
// register file, the ALU-operation decoder and the 64-bit ALU.
//
// Register reads, the decoded operation and the ALU result are combinational.
// Register writeback happens at the rising edge of clk.
//
// Ports
//   clk          in   1     system clock, rising edge
//   reset        in   1     synchronous active-high reset; clears every register
//   regwrite     in   1     register write enable
//   rs1_addr     in   5     read address 1 (instruction[19:15])
//   rs2_addr     in   5     read address 2 (instruction[24:20])
//   rd_addr      in   5     write address (instruction[11:7]); x0 is never written
//   rd_data      in   64    writeback data
//   instruction  in   32    current instruction; funct3 and funct7[5] are used
//   alusel1      in   3     ALU class from main control
//   alu_b        in   64    ALU operand B (register or immediate, muxed outside)
//   reg_out1     out  64    register[rs1_addr]; this is also ALU operand A
//   reg_out2     out  64    register[rs2_addr]
//   alusel2      out  3     decoded ALU operation
//   alu_out      out  64    ALU result
//   alu_zero     out  1     alu_out == 0
//   alu_ovr      out  1     signed overflow of ADD/SUB, otherwise 0
// ---------------------------------------------------------------------------
module exec_datapath_core #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regwrite,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [31:0]     instruction,
    input  logic [2:0]      alusel1,
    input  logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] reg_out1,
    output logic [XLEN-1:0] reg_out2,
    output logic [2:0]      alusel2,
    output logic [XLEN-1:0] alu_out,
    output logic            alu_zero,
    output logic            alu_ovr
);

    localparam int SHW = $clog2(XLEN);

    // ALU operation encoding carried on alusel2
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // -----------------------------------------------------------------------
    // Register file: one row per generate iteration. Row 0 never sees a write
    // enable, so it holds zero after reset. The read mux below also forces x0
    // to zero, which covers the time before the first reset.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = regwrite && (rd_addr != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_row
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else if (wr_en && (rd_addr == 5'(gi))) begin
                    regs_q[gi] <= rd_data;
                end
            end
        end
    endgenerate

    // Reads see the stored value, so a same-cycle write becomes visible only
    // after the edge.
    assign reg_out1 = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
    assign reg_out2 = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];

    // -----------------------------------------------------------------------
    // ALU-operation decode
    // -----------------------------------------------------------------------
    logic [2:0] funct3;
    logic       funct7_b5;

    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    always_comb begin
        alusel2 = OP_ADD;
        case (alusel1)
            3'b000: alusel2 = OP_ADD;    // load/store address
            3'b001: alusel2 = OP_SUB;    // branch compare
            3'b010, 3'b011: begin        // R-type / I-type arithmetic
                case (funct3)
                    3'b000: alusel2 = (alusel1 == 3'b010 && funct7_b5) ? OP_SUB : OP_ADD;
                    3'b001: alusel2 = OP_SLL;
                    3'b010: alusel2 = OP_SLT;
                    3'b011: alusel2 = OP_ADD;
                    3'b100: alusel2 = OP_XOR;
                    3'b101: alusel2 = OP_SRL;
                    3'b110: alusel2 = OP_OR;
                    3'b111: alusel2 = OP_AND;
                    default: alusel2 = OP_ADD;
                endcase
            end
            default: alusel2 = OP_ADD;   // unused classes
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic            slt;

    assign op_a  = reg_out1;
    assign sum   = op_a + alu_b;
    assign diff  = op_a - alu_b;
    assign shamt = alu_b[SHW-1:0];
    assign slt   = $signed(op_a) < $signed(alu_b);

    always_comb begin
        alu_out = '0;
        alu_ovr = 1'b0;
        case (alusel2)
            OP_AND: alu_out = op_a & alu_b;
            OP_OR:  alu_out = op_a | alu_b;
            OP_ADD: begin
                alu_out = sum;
                // Operands agree in sign but the result does not
                alu_ovr = (op_a[XLEN-1] == alu_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            end
            OP_XOR: alu_out = op_a ^ alu_b;
            OP_SLL: alu_out = op_a << shamt;
            OP_SRL: alu_out = op_a >> shamt;
            OP_SUB: begin
                alu_out = diff;
                // Operands differ in sign and the result left A's sign
                alu_ovr = (op_a[XLEN-1] != alu_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
            end
            OP_SLT: alu_out = {{(XLEN-1){1'b0}}, slt};
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    // Remaining instruction fields are decoded elsewhere in the processor
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:0]};

endmodule

// File: tb/tb_exec_datapath_core.sv
module tb_exec_datapath_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [63:0] rd_data;
    logic [31:0] instruction;
    logic [2:0]  alusel1;
    logic [63:0] alu_b;
    logic [63:0] reg_out1, reg_out2;
    logic [2:0]  alusel2;
    logic [63:0] alu_out;
    logic        alu_zero, alu_ovr;

    exec_datapath_core dut (
        .clk        (clk),
        .reset      (reset),
        .regwrite   (regwrite),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .instruction(instruction),
        .alusel1    (alusel1),
        .alu_b      (alu_b),
        .reg_out1   (reg_out1),
        .reg_out2   (reg_out2),
        .alusel2    (alusel2),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_ovr    (alu_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] value;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] model_regs [32];

    // ---------------- scoreboard push and reference models ----------------
    function automatic void expect_val(string n, logic [63:0] v);
        exp_t x;
        x.name  = n;
        x.value = v;
        sb_q.push_back(x);
    endfunction

    function automatic logic [2:0] ref_decode(logic [2:0] s1, logic [2:0] f3, logic f7b5);
        if (s1 == 3'b001) return 3'b110;
        if (s1 != 3'b010 && s1 != 3'b011) return 3'b010;
        case (f3)
            3'd0: return (s1 == 3'b010 && f7b5) ? 3'b110 : 3'b010;
            3'd1: return 3'b100;
            3'd2: return 3'b111;
            3'd3: return 3'b010;
            3'd4: return 3'b011;
            3'd5: return 3'b101;
            3'd6: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Overflow taken from a sign-extended 65-bit computation
    function automatic logic [63:0] ref_alu(logic [2:0] op, logic [63:0] a, logic [63:0] b,
                                            output logic ovr);
        logic [64:0] w;
        ovr = 1'b0;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: begin w = {a[63], a} + {b[63], b}; ovr = w[64] ^ w[63]; return w[63:0]; end
            3'b011: return a ^ b;
            3'b100: return a << b[5:0];
            3'b101: return a >> b[5:0];
            3'b110: begin w = {a[63], a} - {b[63], b}; ovr = w[64] ^ w[63]; return w[63:0]; end
            default: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        regwrite = 1'b1; rd_addr = a; rd_data = d;
        tick();
        regwrite = 1'b0;
        if (a != 5'd0) model_regs[a] = d;
    endtask

    task automatic set_op(input logic [2:0] s1, input logic [2:0] f3, input logic f7b5);
        instruction        = $urandom;
        instruction[14:12] = f3;
        instruction[30]    = f7b5;
        alusel1            = s1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; regwrite = 1'b0;
        tick();
        reset = 1'b0;
        foreach (model_regs[i]) model_regs[i] = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd31; alu_b = 64'd7; set_op(3'b000, 3'd0, 1'b0);
        #1;
        expect_val("reset_rs1", 64'd0);
        expect_val("reset_rs2", 64'd0);
        expect_val("reset_alu", 64'd7);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
        e = sb_q.pop_front(); checks++;
        if (reg_out2 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out2, e.value); end
        else $display("ok   %s: %h", e.name, reg_out2);
        e = sb_q.pop_front(); checks++;
        if (alu_out !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, alu_out, e.value); end
        else $display("ok   %s: %h", e.name, alu_out);
    endtask

    task automatic test_reset_after_write();
        write_reg(5'd5, 64'hDEAD_BEEF_0000_0005);
        rs1_addr = 5'd5; #1;
        expect_val("x5_written", 64'hDEAD_BEEF_0000_0005);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
        reset = 1'b1; tick(); reset = 1'b0;
        foreach (model_regs[i]) model_regs[i] = '0;
        expect_val("x5_after_reset", 64'd0);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
        write_reg(5'd5, 64'h1234);
        expect_val("x5_rewritten", 64'h1234);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
    endtask

    task automatic test_x0();
        write_reg(5'd0, 64'hFFFF);
        rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
        expect_val("x0_rs1", 64'd0);
        expect_val("x0_rs2", 64'd0);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
        e = sb_q.pop_front(); checks++;
        if (reg_out2 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out2, e.value); end
        else $display("ok   %s: %h", e.name, reg_out2);
    endtask

    task automatic test_read_old_value();
        write_reg(5'd7, 64'hAAAA);
        regwrite = 1'b1; rd_addr = 5'd7; rd_data = 64'h5555; rs2_addr = 5'd7; #1;
        expect_val("same_cycle_old", 64'hAAAA);
        e = sb_q.pop_front(); checks++;
        if (reg_out2 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out2, e.value); end
        else $display("ok   %s: %h", e.name, reg_out2);
        tick(); regwrite = 1'b0; model_regs[7] = 64'h5555;
        expect_val("after_edge_new", 64'h5555);
        e = sb_q.pop_front(); checks++;
        if (reg_out2 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out2, e.value); end
        else $display("ok   %s: %h", e.name, reg_out2);
    endtask

    task automatic test_decode();
        for (int s = 0; s < 8; s++) begin
            for (int f = 0; f < 8; f++) begin
                for (int b = 0; b < 2; b++) begin
                    set_op(3'(s), 3'(f), 1'(b)); #1;
                    expect_val($sformatf("dec_s%0d_f%0d_b%0d", s, f, b),
                               {61'd0, ref_decode(3'(s), 3'(f), 1'(b))});
                    e = sb_q.pop_front(); checks++;
                    if ({61'd0, alusel2} !== e.value) begin
                        errors++; $display("FAIL %s: got=%0d want=%0d", e.name, alusel2, e.value);
                    end else $display("ok   %s: %0d", e.name, alusel2);
                end
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  s1;
        logic [2:0]  f3;
        logic        f7b5;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
        logic        zero;
        logic        ovr;
    } vec_t;

    task automatic test_alu_vectors();
        vec_t v [12];
        v[0]  = '{"sub_eq",    3'b010, 3'd0, 1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0};
        v[1]  = '{"add_ovr",   3'b000, 3'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        v[2]  = '{"sub_ovr",   3'b001, 3'd0, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        v[3]  = '{"slt_neg",   3'b010, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0};
        v[4]  = '{"slt_pos",   3'b011, 3'd2, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0};
        v[5]  = '{"sll_63",    3'b010, 3'd1, 1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        v[6]  = '{"srl_63",    3'b011, 3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0};
        v[7]  = '{"sll_wrap",  3'b010, 3'd1, 1'b0, 64'd3, 64'd64, 64'd3, 1'b0, 1'b0};
        v[8]  = '{"add_wrap",  3'b011, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
        v[9]  = '{"and",       3'b010, 3'd7, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
        v[10] = '{"or",        3'b011, 3'd6, 1'b0, 64'hF0F0, 64'h0F00, 64'hFFF0, 1'b0, 1'b0};
        v[11] = '{"xor",       3'b010, 3'd4, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1'b0};
        foreach (v[i]) begin
            write_reg(5'd1, v[i].a);
            rs1_addr = 5'd1; alu_b = v[i].b; set_op(v[i].s1, v[i].f3, v[i].f7b5); #1;
            expect_val({v[i].name, "_out"},  v[i].out);
            expect_val({v[i].name, "_zero"}, {63'd0, v[i].zero});
            expect_val({v[i].name, "_ovr"},  {63'd0, v[i].ovr});
            e = sb_q.pop_front(); checks++;
            if (alu_out !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, alu_out, e.value); end
            else $display("ok   %s: %h", e.name, alu_out);
            e = sb_q.pop_front(); checks++;
            if ({63'd0, alu_zero} !== e.value) begin errors++; $display("FAIL %s: got=%b want=%0d", e.name, alu_zero, e.value); end
            else $display("ok   %s: %b", e.name, alu_zero);
            e = sb_q.pop_front(); checks++;
            if ({63'd0, alu_ovr} !== e.value) begin errors++; $display("FAIL %s: got=%b want=%0d", e.name, alu_ovr, e.value); end
            else $display("ok   %s: %b", e.name, alu_ovr);
        end
    endtask

    task automatic test_reset_beats_write();
        write_reg(5'd3, 64'd77);
        reset = 1'b1; regwrite = 1'b1; rd_addr = 5'd3; rd_data = 64'd99;
        tick();
        reset = 1'b0; regwrite = 1'b0;
        foreach (model_regs[i]) model_regs[i] = '0;
        rs1_addr = 5'd3; #1;
        expect_val("reset_beats_write", 64'd0);
        e = sb_q.pop_front(); checks++;
        if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
        else $display("ok   %s: %h", e.name, reg_out1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, exp_out;
        logic        exp_ovr;
        for (int n = 0; n < 40; n++) begin
            regwrite = 1'($urandom_range(0, 3) != 0);
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = {$urandom, $urandom};
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            alu_b    = (n % 4 == 0) ? model_regs[rs1_addr] : {$urandom, $urandom};
            set_op(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            #1;
            a       = model_regs[rs1_addr];
            exp_out = ref_alu(ref_decode(alusel1, instruction[14:12], instruction[30]), a, alu_b, exp_ovr);
            expect_val($sformatf("b2b%0d_rs1", n), a);
            expect_val($sformatf("b2b%0d_rs2", n), model_regs[rs2_addr]);
            expect_val($sformatf("b2b%0d_alu", n), exp_out);
            expect_val($sformatf("b2b%0d_flags", n), {62'd0, exp_out == 64'd0, exp_ovr});
            e = sb_q.pop_front(); checks++;
            if (reg_out1 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out1, e.value); end
            else $display("ok   %s: %h", e.name, reg_out1);
            e = sb_q.pop_front(); checks++;
            if (reg_out2 !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, reg_out2, e.value); end
            else $display("ok   %s: %h", e.name, reg_out2);
            e = sb_q.pop_front(); checks++;
            if (alu_out !== e.value) begin errors++; $display("FAIL %s: got=%h want=%h", e.name, alu_out, e.value); end
            else $display("ok   %s: %h", e.name, alu_out);
            e = sb_q.pop_front(); checks++;
            if ({62'd0, alu_zero, alu_ovr} !== e.value) begin
                errors++; $display("FAIL %s: got zero/ovr=%b%b want=%b", e.name, alu_zero, alu_ovr, e.value[1:0]);
            end else $display("ok   %s: %b%b", e.name, alu_zero, alu_ovr);
            tick();
            if (regwrite && rd_addr != 5'd0) model_regs[rd_addr] = rd_data;
        end
        regwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; regwrite = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0;
        instruction = '0; alusel1 = '0; alu_b = '0;
        test_reset();
        test_reset_after_write();
        test_x0();
        test_read_old_value();
        test_decode();
        test_alu_vectors();
        test_reset_beats_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
